// File: rtl/gate_demo_pkg.sv
// Shared mode encoding and mode indicator decode for the gate demonstrator.
// Both the top level and the bench use these so the mode numbering cannot drift.
package gate_demo_pkg;

    localparam int MODE_W = 3;
    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_AND  = 3'd0;
    localparam mode_t MODE_OR   = 3'd1;
    localparam mode_t MODE_NAND = 3'd2;
    localparam mode_t MODE_NOR  = 3'd3;
    localparam mode_t MODE_XOR  = 3'd4;
    localparam mode_t MODE_XNOR = 3'd5;

    localparam int    NUM_MODES  = 6;
    localparam mode_t MODE_RESET = MODE_NOR;

    // Unused codes 6..7 decode to all-zero so a corrupted mode shows no LED.
    function automatic logic [NUM_MODES-1:0] mode_onehot(input mode_t mode);
        logic [NUM_MODES-1:0] onehot;
        onehot = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            onehot[i] = (mode == mode_t'(i));
        end
        return onehot;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stability counter; the output only
// follows the input once it has held a new level for DEBOUNCE_CYCLES clocks.
module debounce_filter #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic stable
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= async_in;
            sync2_reg <= sync1_reg;
            // Any return to the accepted level restarts the count from zero.
            if (sync2_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg <= sync2_reg;
                cnt_reg    <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
            end
        end
    end

    assign stable = stable_reg;

endmodule

// File: rtl/multi_gate_demonstrator.sv
// Board-level gate demo: debounced switches feed a mode-selectable reduction
// gate; a debounced push button steps through the six gate modes.
module multi_gate_demonstrator
    import gate_demo_pkg::*;
#(
    parameter int NUM_INPUTS      = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  I_P_CLK,
    input  logic                  I_P_RST_N,
    input  logic [NUM_INPUTS-1:0] I_P_SW,
    input  logic                  I_P_BTN_MODE,
    output logic [NUM_INPUTS-1:0] O_P_LED_IN,
    output logic                  O_P_LED_GATE,
    output logic [NUM_MODES-1:0]  O_P_LED_MODE
);

    // Bit NUM_INPUTS carries the mode button; the rest are the switches.
    logic [NUM_INPUTS:0]   raw_in;
    logic [NUM_INPUTS:0]   stable_in;
    logic [NUM_INPUTS-1:0] sw_stable;
    logic                  btn_stable;

    assign raw_in = {I_P_BTN_MODE, I_P_SW};

    genvar gi;
    generate
        for (gi = 0; gi <= NUM_INPUTS; gi++) begin : gen_filter
            debounce_filter #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_filter (
                .clk     (I_P_CLK),
                .rst_n   (I_P_RST_N),
                .async_in(raw_in[gi]),
                .stable  (stable_in[gi])
            );
        end
    endgenerate

    assign sw_stable  = stable_in[NUM_INPUTS-1:0];
    assign btn_stable = stable_in[NUM_INPUTS];

    mode_t mode_reg;
    mode_t mode_next;
    logic  btn_dly_reg;
    logic  gate_reg;
    logic  gate_next;

    // The >= compare also folds the unreachable codes back to AND.
    always_comb begin
        mode_next = mode_reg + mode_t'(1);
        if (mode_reg >= mode_t'(NUM_MODES - 1)) begin
            mode_next = MODE_AND;
        end
    end

    always_comb begin
        gate_next = 1'b0;
        case (mode_reg)
            MODE_AND:  gate_next =   &sw_stable;
            MODE_OR:   gate_next =   |sw_stable;
            MODE_NAND: gate_next = ~(&sw_stable);
            MODE_NOR:  gate_next = ~(|sw_stable);
            MODE_XOR:  gate_next =   ^sw_stable;
            MODE_XNOR: gate_next = ~(^sw_stable);
            default:   gate_next = 1'b0;
        endcase
    end

    always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
        if (!I_P_RST_N) begin
            mode_reg    <= MODE_RESET;
            btn_dly_reg <= 1'b0;
            gate_reg    <= 1'b1;
        end else begin
            btn_dly_reg <= btn_stable;
            if (btn_stable && !btn_dly_reg) begin
                mode_reg <= mode_next;
            end
            gate_reg <= gate_next;
        end
    end

    assign O_P_LED_IN   = sw_stable;
    assign O_P_LED_GATE = gate_reg;
    assign O_P_LED_MODE = mode_onehot(mode_reg);

endmodule

// File: tb/tb_multi_gate_demonstrator.sv
// Bench for multi_gate_demonstrator with NUM_INPUTS=3, DEBOUNCE_CYCLES=4:
// expectations are queued with a due cycle and compared as each cycle elapses.
module tb_multi_gate_demonstrator;

    localparam int N   = 3;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] sw;
    logic         btn;
    logic [N-1:0] led_in;
    logic         led_gate;
    logic [5:0]   led_mode;

    multi_gate_demonstrator #(
        .NUM_INPUTS     (N),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .I_P_CLK     (clk),
        .I_P_RST_N   (rst_n),
        .I_P_SW      (sw),
        .I_P_BTN_MODE(btn),
        .O_P_LED_IN  (led_in),
        .O_P_LED_GATE(led_gate),
        .O_P_LED_MODE(led_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [N-1:0] in_e;
        logic         gate_e;
        logic [5:0]   mode_e;
        string        tag;
    } exp_t;

    typedef struct {
        logic [N-1:0] sw;
        logic         gate;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Bench's own view of the DUT state after settling.
    logic [N-1:0] cur_in;
    logic         cur_gate;
    int           cur_m;
    // Gate result for switches 111, indexed by mode code AND..XNOR.
    logic [5:0]   gate111;

    function automatic logic [5:0] onehot(input int m);
        logic [5:0] one;
        one = 6'b000001;
        return one << m;
    endfunction

    task automatic check(input string tag, input logic [N-1:0] in_e,
                         input logic gate_e, input logic [5:0] mode_e);
        checks++;
        if (led_in !== in_e || led_gate !== gate_e || led_mode !== mode_e) begin
            errors++;
            $display("FAIL %s cyc=%0d: got in=%b gate=%b mode=%b, expected in=%b gate=%b mode=%b",
                     tag, cyc, led_in, led_gate, led_mode, in_e, gate_e, mode_e);
        end else begin
            $display("ok   %s cyc=%0d: in=%b gate=%b mode=%b", tag, cyc, led_in, led_gate, led_mode);
        end
    endtask

    task automatic expect_at(input int delay, input logic [N-1:0] in_e,
                             input logic gate_e, input logic [5:0] mode_e, input string tag);
        exp_t e;
        e.due    = cyc + delay;
        e.in_e   = in_e;
        e.gate_e = gate_e;
        e.mode_e = mode_e;
        e.tag    = tag;
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                check(e.tag, e.in_e, e.gate_e, e.mode_e);
            end
        end
    endtask

    task automatic apply_sw(input logic [N-1:0] new_sw, input logic new_gate);
        sw = new_sw;
        expect_at(5, cur_in, cur_gate, onehot(cur_m), "sw_before_accept");
        expect_at(6, new_sw, cur_gate, onehot(cur_m), "sw_accept");
        expect_at(7, new_sw, new_gate, onehot(cur_m), "sw_gate");
        run(9);
        cur_in   = new_sw;
        cur_gate = new_gate;
    endtask

    task automatic press();
        int   nm;
        logic ng;
        nm  = (cur_m + 1) % 6;
        ng  = gate111[nm];
        btn = 1'b1;
        expect_at(6,  cur_in, cur_gate, onehot(cur_m), "press_before");
        expect_at(7,  cur_in, cur_gate, onehot(nm),    "press_mode");
        expect_at(8,  cur_in, ng,       onehot(nm),    "press_gate");
        expect_at(50, cur_in, ng,       onehot(nm),    "press_held");
        run(50);
        btn = 1'b0;
        expect_at(10, cur_in, ng, onehot(nm), "press_release");
        run(12);
        cur_m    = nm;
        cur_gate = ng;
    endtask

    initial begin
        vecs[0] = '{3'b101, 1'b0};
        vecs[1] = '{3'b000, 1'b1};
        vecs[2] = '{3'b111, 1'b0};
        vecs[3] = '{3'b010, 1'b0};
        vecs[4] = '{3'b000, 1'b1};
        gate111 = 6'b010011;

        rst_n = 1'b0;
        sw    = '0;
        btn   = 1'b0;
        cur_in   = '0;
        cur_gate = 1'b1;
        cur_m    = 3;
        repeat (3) @(posedge clk);
        #1;
        check("in_reset", 3'b000, 1'b1, 6'b001000);
        rst_n = 1'b1;

        for (int d = 1; d <= 20; d++) expect_at(d, 3'b000, 1'b1, 6'b001000, "reset_idle");
        run(20);

        // Clean switch patterns in the reset (NOR) mode.
        for (int v = 0; v < 5; v++) apply_sw(vecs[v].sw, vecs[v].gate);

        // Three-cycle glitch on SW0 is shorter than the debounce window.
        for (int d = 1; d <= 15; d++) expect_at(d, 3'b000, 1'b1, 6'b001000, "glitch3");
        sw = 3'b001; run(3); sw = 3'b000; run(12);

        // Two three-cycle bursts separated by one matching cycle.
        for (int d = 1; d <= 20; d++) expect_at(d, 3'b000, 1'b1, 6'b001000, "bounce");
        sw = 3'b001; run(3); sw = 3'b000; run(1); sw = 3'b001; run(3); sw = 3'b000; run(13);

        // Exactly DEBOUNCE_CYCLES of high is accepted, then drops back.
        expect_at(5,  3'b000, 1'b1, 6'b001000, "pulse4_pre");
        expect_at(6,  3'b001, 1'b1, 6'b001000, "pulse4_accept");
        expect_at(7,  3'b001, 1'b0, 6'b001000, "pulse4_gate");
        expect_at(9,  3'b001, 1'b0, 6'b001000, "pulse4_hold");
        expect_at(10, 3'b000, 1'b0, 6'b001000, "pulse4_drop");
        expect_at(11, 3'b000, 1'b1, 6'b001000, "pulse4_gate_back");
        sw = 3'b001; run(4); sw = 3'b000; run(12);

        // Six presses walk every mode once with all switches high.
        apply_sw(3'b111, 1'b0);
        for (int k = 0; k < 6; k++) press();

        // XOR mode: dropping one switch flips odd parity to even.
        press();
        apply_sw(3'b110, 1'b0);

        // Mode advance and switch acceptance land on the same edge.
        btn = 1'b1;
        run(1);
        sw = 3'b111;
        expect_at(5, 3'b110, 1'b0, onehot(4), "simul_before");
        expect_at(6, 3'b111, 1'b0, onehot(5), "simul_accept");
        expect_at(7, 3'b111, 1'b0, onehot(5), "simul_both_new");
        expect_at(9, 3'b111, 1'b0, onehot(5), "simul_hold");
        run(20);
        btn = 1'b0;
        run(12);
        cur_m = 5; cur_in = 3'b111; cur_gate = 1'b0;

        // Reset lands while the button counter is at 2.
        btn = 1'b1;
        expect_at(4, 3'b111, 1'b0, onehot(5), "pre_reset");
        run(4);
        rst_n = 1'b0;
        #1;
        check("reset_async", 3'b000, 1'b1, 6'b001000);
        run(2);
        check("reset_held", 3'b000, 1'b1, 6'b001000);
        rst_n = 1'b1;
        expect_at(5,  3'b000, 1'b1, 6'b001000, "held_before");
        expect_at(6,  3'b111, 1'b1, 6'b001000, "held_sw_accept");
        expect_at(7,  3'b111, 1'b0, 6'b010000, "held_advance");
        expect_at(8,  3'b111, 1'b1, 6'b010000, "held_xor_gate");
        expect_at(40, 3'b111, 1'b1, 6'b010000, "held_once");
        run(40);
        btn = 1'b0;
        expect_at(10, 3'b111, 1'b1, 6'b010000, "held_release");
        run(10);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
